// File: rtl/ppu_issue_ctrl.sv
// rtl/ppu_issue_ctrl.sv - round-robin issue controller for the shared multi-cycle PPU datapath
// Optional PPU_ISSUE_PERF_EN adds perf_ops_o / perf_busy_o counters.
module ppu_issue_ctrl #(
   parameter int NREQ     = 2,
   parameter int OP_SIZE  = 3,
   parameter int LAT_ADD  = 2,
   parameter int LAT_MUL  = 2,
   parameter int LAT_DIV  = 3,
   parameter int LAT_CONV = 1,
   localparam int ID_W    = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid_i,
   input  logic [NREQ*OP_SIZE-1:0] req_op_i,
   output logic [NREQ-1:0]         req_ready_o,
   output logic                    dp_start_o,
   output logic [OP_SIZE-1:0]      dp_op_o,
   output logic [ID_W-1:0]         dp_sel_o,
   output logic                    rsp_valid_o,
   output logic [ID_W-1:0]         rsp_id_o,
   output logic                    rsp_err_o,
   input  logic                    rsp_ready_i
`ifdef PPU_ISSUE_PERF_EN
   ,
   output logic [31:0]             perf_ops_o,
   output logic [31:0]             perf_busy_o
`endif
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               dp_start_q, dp_start_d;
   logic [OP_SIZE-1:0] dp_op_q, dp_op_d;
   logic [ID_W-1:0]    dp_sel_q, dp_sel_d;
   logic               rsp_err_q, rsp_err_d;

   logic [NREQ-1:0]    rot_valid;
   logic [ID_W:0]      grant_sum;
   logic               grant_found;
   logic [ID_W-1:0]    grant_id;
   logic [OP_SIZE-1:0] grant_op;
   logic               grant_illegal;

`ifdef PPU_ISSUE_PERF_EN
   logic [31:0]        perf_ops_q, perf_ops_d;
   logic [31:0]        perf_busy_q, perf_busy_d;
`endif

   // Busy cycles minus one, so the counter exits BUSY on zero.
   function automatic logic [3:0] lat_m1(input logic [OP_SIZE-1:0] op);
      case (op)
         OP_SIZE'(0), OP_SIZE'(1): lat_m1 = 4'(LAT_ADD - 1);
         OP_SIZE'(2):              lat_m1 = 4'(LAT_MUL - 1);
         OP_SIZE'(3):              lat_m1 = 4'(LAT_DIV - 1);
         OP_SIZE'(4), OP_SIZE'(5): lat_m1 = 4'(LAT_CONV - 1);
         default:                  lat_m1 = 4'd0;
      endcase
   endfunction

   // Rotate valids so bit 0 is rr_ptr; the lowest set rotated bit wins.
   always_comb begin
      rot_valid   = NREQ'({req_valid_i, req_valid_i} >> rr_ptr_q);
      grant_found = 1'b0;
      grant_id    = '0;
      grant_sum   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot_valid[i]) begin
            grant_found = 1'b1;
            grant_sum   = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (grant_sum >= (ID_W+1)'(NREQ)) begin
               grant_sum = grant_sum - (ID_W+1)'(NREQ);
            end
            grant_id = grant_sum[ID_W-1:0];
         end
      end
      grant_op = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (grant_id == ID_W'(j)) begin
            grant_op = req_op_i[j*OP_SIZE +: OP_SIZE];
         end
      end
      grant_illegal = (grant_op > OP_SIZE'(5));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         dp_start_q <= 1'b0;
         dp_op_q    <= '0;
         dp_sel_q   <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         dp_start_q <= dp_start_d;
         dp_op_q    <= dp_op_d;
         dp_sel_q   <= dp_sel_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      dp_start_d = 1'b0;
      dp_op_d    = dp_op_q;
      dp_sel_d   = dp_sel_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               dp_op_d  = grant_op;
               dp_sel_d = grant_id;
               rr_ptr_d = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
               if (grant_illegal) begin
                  state_d   = RESP;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d    = BUSY;
                  cnt_d      = lat_m1(grant_op);
                  dp_start_d = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d   = IDLE;
               rsp_err_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      if (!rst && state_q == IDLE && grant_found) begin
         req_ready_o[grant_id] = 1'b1;
      end
      rsp_valid_o = (state_q == RESP);
   end

   assign dp_start_o = dp_start_q;
   assign dp_op_o    = dp_op_q;
   assign dp_sel_o   = dp_sel_q;
   assign rsp_id_o   = dp_sel_q;
   assign rsp_err_o  = rsp_err_q;

`ifdef PPU_ISSUE_PERF_EN
   always_comb begin
      perf_ops_d  = perf_ops_q;
      perf_busy_d = perf_busy_q;
      if (state_q == RESP && rsp_ready_i) begin
         perf_ops_d = perf_ops_q + 32'd1;
      end
      if (state_q != IDLE) begin
         perf_busy_d = perf_busy_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops_q  <= '0;
         perf_busy_q <= '0;
      end else begin
         perf_ops_q  <= perf_ops_d;
         perf_busy_q <= perf_busy_d;
      end
   end

   assign perf_ops_o  = perf_ops_q;
   assign perf_busy_o = perf_busy_q;
`endif

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// tb/tb_ppu_issue_ctrl.sv - directed scoreboard bench for ppu_issue_ctrl
module tb_ppu_issue_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] req_valid_i;
   logic [5:0] req_op_i;
   logic [1:0] req_ready_o;
   logic       dp_start_o;
   logic [2:0] dp_op_o;
   logic       dp_sel_o;
   logic       rsp_valid_o;
   logic       rsp_id_o;
   logic       rsp_err_o;
   logic       rsp_ready_i;
`ifdef PPU_ISSUE_PERF_EN
   logic [31:0] perf_ops_o;
   logic [31:0] perf_busy_o;
`endif

   ppu_issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_op_i    (req_op_i),
      .req_ready_o (req_ready_o),
      .dp_start_o  (dp_start_o),
      .dp_op_o     (dp_op_o),
      .dp_sel_o    (dp_sel_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_id_o    (rsp_id_o),
      .rsp_err_o   (rsp_err_o),
      .rsp_ready_i (rsp_ready_i)
`ifdef PPU_ISSUE_PERF_EN
      ,
      .perf_ops_o  (perf_ops_o),
      .perf_busy_o (perf_busy_o)
`endif
   );

   typedef struct {
      logic       id;
      logic       err;
      logic [2:0] op;
   } rsp_t;

   rsp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && rsp_valid_o && rsp_ready_i) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_rsp", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = sb_q.pop_front();
            chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            chk("rsp_op", 32'(dp_op_o), 32'(e.op));
         end
      end
   end

   // Inputs already driven; expects grant to id, then response exp_cycles later.
   task automatic run_op(input logic id, input logic [2:0] op, input int exp_cycles);
      rsp_t e;
      int   n;
      settle();
      chk("grant", 32'(req_ready_o), (id ? 32'd2 : 32'd1));
      e.id = id; e.err = (op >= 3'd6); e.op = op;
      sb_q.push_back(e);
      tick();
      chk("start_pulse", 32'(dp_start_o), (op >= 3'd6) ? 32'd0 : 32'd1);
      n = 1;
      while (!rsp_valid_o && n < 20) begin
         tick();
         n++;
      end
      chk("rsp_latency", 32'(n), 32'(exp_cycles));
      chk("bubble_ready", 32'(req_ready_o), 32'd0);
      tick();
   endtask

   initial begin
      rst = 1'b1; req_valid_i = 2'b11; req_op_i = '0; rsp_ready_i = 1'b1;
      tick(); tick();
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_dp_start", 32'(dp_start_o), 32'd0);
      chk("rst_dp_op", 32'(dp_op_o), 32'd0);
      chk("rst_dp_sel", 32'(dp_sel_o), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      rst = 1'b0; req_valid_i = 2'b00;
      tick();

      // single ADD from req0
      req_valid_i = 2'b01; req_op_i = {3'd0, 3'd0};
      settle();
      chk("add_c0_ready", 32'(req_ready_o), 32'd1);
      chk("add_c0_start", 32'(dp_start_o), 32'd0);
      sb_q.push_back('{id: 1'b0, err: 1'b0, op: 3'd0});
      tick();
      req_valid_i = 2'b00;
      settle();
      chk("add_c1_start", 32'(dp_start_o), 32'd1);
      chk("add_c1_valid", 32'(rsp_valid_o), 32'd0);
      tick();
      chk("add_c2_start", 32'(dp_start_o), 32'd0);
      chk("add_c2_valid", 32'(rsp_valid_o), 32'd0);
      tick();
      chk("add_c3_valid", 32'(rsp_valid_o), 32'd1);
      chk("add_c3_id", 32'(rsp_id_o), 32'd0);
      chk("add_c3_err", 32'(rsp_err_o), 32'd0);
      tick();
      chk("add_c4_valid", 32'(rsp_valid_o), 32'd0);

      // illegal op 7 from req1 (rr_ptr now 1)
      req_valid_i = 2'b10; req_op_i = {3'd7, 3'd0};
      settle();
      chk("ill_c0_ready", 32'(req_ready_o), 32'd2);
      sb_q.push_back('{id: 1'b1, err: 1'b1, op: 3'd7});
      tick();
      req_valid_i = 2'b00;
      settle();
      chk("ill_c1_start", 32'(dp_start_o), 32'd0);
      chk("ill_c1_valid", 32'(rsp_valid_o), 32'd1);
      chk("ill_c1_err", 32'(rsp_err_o), 32'd1);
      chk("ill_c1_id", 32'(rsp_id_o), 32'd1);
      tick();
      chk("ill_c2_valid", 32'(rsp_valid_o), 32'd0);
      chk("ill_c2_err", 32'(rsp_err_o), 32'd0);

      // both requesters hold DIV: grants alternate starting at 0
      req_valid_i = 2'b11; req_op_i = {3'd3, 3'd3};
      for (int k = 0; k < 4; k++) begin
         run_op(k[0], 3'd3, 4);
      end
      req_valid_i = 2'b00;
      tick();

      // MUL with 10 cycles of backpressure; req1 keeps requesting meanwhile
      req_valid_i = 2'b01; req_op_i = {3'd1, 3'd2}; rsp_ready_i = 1'b0;
      settle();
      chk("mul_c0_ready", 32'(req_ready_o), 32'd1);
      sb_q.push_back('{id: 1'b0, err: 1'b0, op: 3'd2});
      tick();
      req_valid_i = 2'b11;
      for (int k = 1; k <= 12; k++) begin
         settle();
         chk("mul_hold_ready", 32'(req_ready_o), 32'd0);
         chk("mul_hold_valid", 32'(rsp_valid_o), (k >= 3) ? 32'd1 : 32'd0);
         if (k >= 3) begin
            chk("mul_hold_id", 32'(rsp_id_o), 32'd0);
            chk("mul_hold_op", 32'(dp_op_o), 32'd2);
         end
         tick();
      end
      rsp_ready_i = 1'b1; req_valid_i = 2'b00;
      settle();
      chk("mul_final_valid", 32'(rsp_valid_o), 32'd1);
      tick();
      chk("mul_done_valid", 32'(rsp_valid_o), 32'd0);

      // reset during DIV busy (rr_ptr is 1 before reset)
      req_valid_i = 2'b01; req_op_i = {3'd0, 3'd3};
      settle();
      chk("div_c0_ready", 32'(req_ready_o), 32'd1);
      tick();
      req_valid_i = 2'b00;
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
      chk("mid_rst_op", 32'(dp_op_o), 32'd0);
      chk("mid_rst_sel", 32'(dp_sel_o), 32'd0);
      chk("mid_rst_err", 32'(rsp_err_o), 32'd0);
      chk("mid_rst_start", 32'(dp_start_o), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("no_rsp_after_rst", 32'(rsp_valid_o), 32'd0);
      end
      req_valid_i = 2'b11; req_op_i = {3'd0, 3'd0};
      run_op(1'b0, 3'd0, 3);
      req_valid_i = 2'b10;
      run_op(1'b1, 3'd0, 3);
      req_valid_i = 2'b00;
      tick();

`ifdef PPU_ISSUE_PERF_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_valid_i = 2'b01;
      req_op_i = {3'd0, 3'd0};
      run_op(1'b0, 3'd0, 3);
      req_op_i = {3'd0, 3'd2};
      run_op(1'b0, 3'd2, 3);
      req_op_i = {3'd0, 3'd4};
      run_op(1'b0, 3'd4, 2);
      req_valid_i = 2'b00;
      chk("perf_ops", perf_ops_o, 32'd3);
      chk("perf_busy", perf_busy_o, 32'd8);
`endif

      tick();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
